// File: rtl/bp_cache.sv
// Purpose : 2-way set-associative branch-prediction cache with two async lookup ports and one sync update port.
// Latency : lookups are combinational (0 cycles); an update is written at the clk edge that samples we=1.
// Backpressure: none; ready=0 while the invalidation sweep runs, and updates issued then are dropped.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset (starts an invalidation sweep)
//   ra0/dout0/hit0   lookup port 0 (fetch prediction)
//   ra1/dout1/hit1   lookup port 1 (lookahead)
//   we/wa/din        update port (resolve stage), read-modify-write of one line
//   flush            single-cycle pulse, restarts the invalidation sweep
//   ready            high when the cache is serviceable (not sweeping)
module bp_cache #(
    parameter int AWIDTH     = 32,
    parameter int DWIDTH     = 32,
    parameter int LINES      = 128,
    parameter int INDEXWIDTH = $clog2(LINES),
    parameter int TAGWIDTH   = AWIDTH - INDEXWIDTH,
    parameter int ENTRYWIDTH = DWIDTH + TAGWIDTH + 1,
    parameter int CACHEWIDTH = 1 + 2 * ENTRYWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] ra0,
    output logic [DWIDTH-1:0] dout0,
    output logic              hit0,
    input  logic [AWIDTH-1:0] ra1,
    output logic [DWIDTH-1:0] dout1,
    output logic              hit1,
    input  logic              we,
    input  logic [AWIDTH-1:0] wa,
    input  logic [DWIDTH-1:0] din,
    input  logic              flush,
    output logic              ready
);

    typedef enum logic {
        ST_FLUSH = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // Line layout: {flag, way2, way1}; way layout: {data, tag, valid}.
    // The array has no reset: it is only trusted after the sweep has cleared it.
    logic [CACHEWIDTH-1:0] lines_q [LINES];

    state_t                state_q, state_d;
    logic [INDEXWIDTH-1:0] cnt_q, cnt_d;
    logic                  ready_q, ready_d;

    logic                  line_we;
    logic [INDEXWIDTH-1:0] line_widx;
    logic [CACHEWIDTH-1:0] line_wdat;

    // Returns {hit, data}; way1 wins when both ways match.
    function automatic logic [DWIDTH:0] probe(input logic [CACHEWIDTH-1:0] line,
                                              input logic [TAGWIDTH-1:0]   tag);
        logic [ENTRYWIDTH-1:0] w1;
        logic [ENTRYWIDTH-1:0] w2;
        w1 = line[ENTRYWIDTH-1:0];
        w2 = line[CACHEWIDTH-2:ENTRYWIDTH];
        if (w1[0] && (w1[TAGWIDTH:1] == tag)) begin
            return {1'b1, w1[ENTRYWIDTH-1:TAGWIDTH+1]};
        end
        if (w2[0] && (w2[TAGWIDTH:1] == tag)) begin
            return {1'b1, w2[ENTRYWIDTH-1:TAGWIDTH+1]};
        end
        return '0;
    endfunction

    // ---------------- lookup ports ----------------
    logic [DWIDTH:0] probe0, probe1;

    always_comb begin
        probe0 = '0;
        probe1 = '0;
        // Outputs are forced to zero while the array may still hold stale or X lines.
        if (ready_q) begin
            probe0 = probe(lines_q[ra0[INDEXWIDTH-1:0]], ra0[AWIDTH-1:INDEXWIDTH]);
            probe1 = probe(lines_q[ra1[INDEXWIDTH-1:0]], ra1[AWIDTH-1:INDEXWIDTH]);
        end
    end

    assign hit0  = probe0[DWIDTH];
    assign dout0 = probe0[DWIDTH-1:0];
    assign hit1  = probe1[DWIDTH];
    assign dout1 = probe1[DWIDTH-1:0];
    assign ready = ready_q;

    // ---------------- update read-modify-write ----------------
    logic [INDEXWIDTH-1:0] w_idx;
    logic [TAGWIDTH-1:0]   w_tag;
    logic [CACHEWIDTH-1:0] w_line;
    logic [ENTRYWIDTH-1:0] w_way1, w_way2, w_new;
    logic                  w_flag, w_hit1, w_hit2;

    always_comb begin
        w_idx  = wa[INDEXWIDTH-1:0];
        w_tag  = wa[AWIDTH-1:INDEXWIDTH];
        w_line = lines_q[w_idx];
        w_flag = w_line[CACHEWIDTH-1];
        w_way2 = w_line[CACHEWIDTH-2:ENTRYWIDTH];
        w_way1 = w_line[ENTRYWIDTH-1:0];
        w_new  = {din, w_tag, 1'b1};
        w_hit1 = w_way1[0] && (w_way1[TAGWIDTH:1] == w_tag);
        w_hit2 = w_way2[0] && (w_way2[TAGWIDTH:1] == w_tag);
    end

    // ---------------- control FSM ----------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_d   = ready_q;
        line_we   = 1'b0;
        line_widx = w_idx;
        line_wdat = '0;

        case (state_q)
            ST_FLUSH: begin
                line_we   = 1'b1;
                line_widx = cnt_q;
                line_wdat = '0;
                if (flush) begin
                    cnt_d = '0;
                end else if (cnt_q == INDEXWIDTH'(LINES - 1)) begin
                    // Leave explicitly instead of letting the counter roll over.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + INDEXWIDTH'(1);
                end
            end
            ST_IDLE: begin
                if (flush) begin
                    // A simultaneous update is dropped: the line would be wiped anyway.
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                end else if (we) begin
                    line_we = 1'b1;
                    // flag=1 names way2 as the next victim; writing a way points it at the other one.
                    if (w_hit1) begin
                        line_wdat = {1'b1, w_way2, w_new};
                    end else if (w_hit2) begin
                        line_wdat = {1'b0, w_new, w_way1};
                    end else if (!w_flag) begin
                        line_wdat = {1'b1, w_way2, w_new};
                    end else begin
                        line_wdat = {1'b0, w_new, w_way1};
                    end
                end
            end
            default: begin
                state_d = ST_FLUSH;
                cnt_d   = '0;
                ready_d = 1'b0;
            end
        endcase

        if (rst) begin
            line_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FLUSH;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            lines_q[line_widx] <= line_wdat;
        end
    end

endmodule

// File: doc/bp_cache.md
Name: bp_cache

Overview:
- 2-way set-associative branch-prediction cache: stores {data, tag, valid} pairs per line plus one replacement flag.
- Provides two asynchronous lookup ports (fetch-stage prediction, second lookahead) and one synchronous update port driven by the resolve stage.
- Each update is a read-modify-write of one line. The line-update rule is the team's standard 2-way hit/FIFO replacement.
- Also owns a sequential invalidation sweep, run after reset and on an explicit flush request.

Parameters:
- AWIDTH, 32, address width (PC bits presented to the cache)
- DWIDTH, 32, stored data width (predicted target/counter payload)
- LINES, 128, number of lines (sets); power of two, >= 2
- INDEXWIDTH, $clog2(LINES), index bits = low bits of address
- TAGWIDTH, AWIDTH-INDEXWIDTH, tag bits = remaining upper address bits
- ENTRYWIDTH, DWIDTH+TAGWIDTH+1, one way: {data, tag, valid}
- CACHEWIDTH, 1+2*ENTRYWIDTH, one line: {flag, way2, way1}

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ra0  in  AWIDTH  lookup address, port 0
- dout0  out  DWIDTH  data of hitting way, port 0
- hit0  out  1  port 0 hit
- ra1  in  AWIDTH  lookup address, port 1
- dout1  out  DWIDTH  data of hitting way, port 1
- hit1  out  1  port 1 hit
- we  in  1  update strobe, sampled on rising clk
- wa  in  AWIDTH  update address
- din  in  DWIDTH  update data
- flush  in  1  single-cycle pulse: invalidate whole cache
- ready  out  1  high when cache is serviceable (not sweeping)

Behaviour:
- Address split:
  - index = addr[INDEXWIDTH-1:0]
  - tag = addr[AWIDTH-1:INDEXWIDTH]
- Line layout:
  - bit CACHEWIDTH-1 = flag
  - [CACHEWIDTH-2:ENTRYWIDTH] = way2
  - [ENTRYWIDTH-1:0] = way1
  - Within a way: bit0 = valid, [TAGWIDTH:1] = tag, [ENTRYWIDTH-1:TAGWIDTH+1] = data.
- Reads are combinational, with zero latency from ra* to dout*/hit*:
  - A way hits when valid=1 and its tag equals the lookup tag.
  - If both ways hit, way1 has priority.
  - On a miss, dout=0 and hit=0.
  - While ready=0, hit0=hit1=0 and dout0=dout1=0.
- Reads reflect array contents as of the last clock edge. There is no write-to-read bypass: an update at edge N is visible to lookups from after edge N.
- Update (state IDLE, we=1): on the clk edge, the line at index(wa) is replaced by the updated line. new entry = {din, tag(wa), 1}.
  - way1 hits: line <= {1, way2, new}
  - else way2 hits: line <= {0, new, way1}
  - else flag=0: line <= {1, way2, new}
  - else flag=1: line <= {0, new, way1}
  - Other lines are unchanged. Updates complete in 1 cycle; back-to-back updates to the same index must each see the prior update's result.
- FSM has two states, FLUSH and IDLE, plus a sweep counter cnt (INDEXWIDTH bits).
  - rst=1: state<=FLUSH, cnt<=0, ready<=0. This applies mid-sweep or mid-operation; the sweep restarts from line 0.
  - FLUSH, each cycle:
    - line[cnt] <= all zeros (flag 0, both valids 0); cnt<=cnt+1.
    - When cnt==LINES-1: state<=IDLE, ready<=1 on the following cycle. The sweep takes exactly LINES cycles.
  - IDLE with flush=1: state<=FLUSH, cnt<=0, ready<=0. If we=1 in the same cycle, flush wins and the update is dropped.
  - FLUSH with flush=1: the counter restarts at 0.
  - FLUSH with we=1: the update is ignored (no array write).
- ready is registered; reset value 0.
- dout*/hit* are combinational; their value during reset is 0 because ready=0.
- Counter wrap: cnt is compared against LINES-1 and never wraps silently.
- Storage must tolerate uninitialised contents; correctness relies only on the sweep.

Test Plan:
1. Release rst, hold we=0 -> ready stays 0 for exactly 128 cycles, then 1. Lookups on both ports during the sweep return hit=0, dout=0.
2. After ready, write wa=0x0000_0104, din=0xDEAD_BEEF, then set ra0=0x104 -> next cycle hit0=1, dout0=0xDEADBEEF. Set ra1=0x0000_0204 (same index, other tag) -> hit1=0, dout1=0.
3. Same index 0x04, in sequence:
   - Write tags A (0x104, data 1), B (0x204, data 2), C (0x304, data 3).
   - Expect C evicts A (way1): 0x104 misses; 0x204 hits data 2; 0x304 hits data 3.
   - Then write D=0x404 -> evicts B; 0x304 still hits.
4. With A in way1 and B in way2, rewrite B with data 0x55 -> B hits 0x55 and A still hits. Then a new tag E replaces way1 (A), because the way2 update set flag to 0.
5. Pulse flush in the same cycle as we=1 (wa=0x108) -> ready drops next cycle and 0x108 never hits. After 128 cycles, all previously written addresses miss.
6. Assert rst at sweep cycle 60 for 1 cycle -> ready stays low for a further 128 cycles after rst deasserts. A write issued mid-sweep is not visible afterwards.
